// File: rtl/keypad_pkg.sv
// Shared constants, column-scan state type and key map for the keypad BCD entry block.
package keypad_pkg;

  localparam logic [3:0] KEY_STAR = 4'hA;
  localparam logic [3:0] KEY_HASH = 4'hB;
  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 3;
  localparam int SNAP_W   = NUM_ROWS * NUM_COLS;

  typedef enum logic [1:0] {
    StCol0,
    StCol1,
    StCol2
  } col_state_e;

  // Layout 1 2 3 / 4 5 6 / 7 8 9 / * 0 #
  function automatic logic [3:0] keymap(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    if (row == 2'd3) begin
      unique case (col)
        2'd0:    code = KEY_STAR;
        2'd1:    code = 4'd0;
        default: code = KEY_HASH;
      endcase
    end else begin
      code = {2'b00, row} * 4'd3 + {2'b00, col} + 4'd1;
    end
    return code;
  endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Column scan, row synchroniser, per-sweep snapshot, debounce and single-press event detection.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEBOUNCE_SCANS = 20
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [NUM_ROWS-1:0] ROW,
  output logic [NUM_COLS-1:0] COL,
  output logic                key_valid,
  output logic [3:0]          key_code
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_SCANS);

  col_state_e state_q, state_d;

  logic [DIV_W-1:0]    div_q, div_d;
  logic [NUM_ROWS-1:0] row_meta_q, row_sync_q;
  logic [NUM_ROWS-1:0] row_pressed;
  logic [SNAP_W-1:0]   snap_q, snap_d;
  logic [SNAP_W-1:0]   sweep_snap;
  logic [SNAP_W-1:0]   prev_q, prev_d;
  logic [SNAP_W-1:0]   accepted_q, accepted_d;
  logic [CNT_W-1:0]    stable_q, stable_d;
  logic                col_tick;
  logic                sweep_done;
  logic                accept;
  logic                press_event;
  logic [3:0]          snap_code;
  logic                key_valid_q;
  logic [3:0]          key_code_q;

  assign col_tick    = (div_q == DIV_LAST);
  assign sweep_done  = col_tick && (state_q == StCol2);
  assign row_pressed = ~row_sync_q;
  assign div_d       = col_tick ? '0 : div_q + 1'b1;

  // Column FSM: state register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= StCol0;
    end else begin
      state_q <= state_d;
    end
  end

  // Column FSM: next state
  always_comb begin
    state_d = state_q;
    if (col_tick) begin
      unique case (state_q)
        StCol0:  state_d = StCol1;
        StCol1:  state_d = StCol2;
        StCol2:  state_d = StCol0;
        default: state_d = StCol0;
      endcase
    end
  end

  // Column FSM: outputs
  always_comb begin
    COL = 3'b110;
    unique case (state_q)
      StCol0:  COL = 3'b110;
      StCol1:  COL = 3'b101;
      StCol2:  COL = 3'b011;
      default: COL = 3'b110;
    endcase
  end

  always_comb begin
    snap_d = snap_q;
    if (col_tick) begin
      unique case (state_q)
        StCol0:  snap_d[3:0]  = row_pressed;
        StCol1:  snap_d[7:4]  = row_pressed;
        StCol2:  snap_d[11:8] = row_pressed;
        default: snap_d       = snap_q;
      endcase
    end
  end

  // Column 2 arrives on the closing sample, so the full sweep is visible in the same cycle.
  always_comb begin
    sweep_snap        = snap_q;
    sweep_snap[11:8]  = row_pressed;
  end

  always_comb begin
    prev_d     = prev_q;
    stable_d   = stable_q;
    accepted_d = accepted_q;
    accept     = 1'b0;
    if (sweep_done) begin
      prev_d = sweep_snap;
      if (sweep_snap == prev_q) begin
        if (stable_q < CNT_MAX) begin
          stable_d = stable_q + 1'b1;
          if (stable_d == CNT_MAX) begin
            accept     = 1'b1;
            accepted_d = sweep_snap;
          end
        end
      end else begin
        stable_d = '0;
      end
    end
  end

  always_comb begin
    snap_code = '0;
    for (int c = 0; c < NUM_COLS; c++) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        if (sweep_snap[c*NUM_ROWS+r]) begin
          snap_code = keymap(2'(r), 2'(c));
        end
      end
    end
  end

  // Only released -> single key counts; multi-key states must drain back to released first.
  assign press_event = accept && (accepted_q == '0) && $onehot(sweep_snap);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      div_q       <= '0;
      row_meta_q  <= '1;
      row_sync_q  <= '1;
      snap_q      <= '0;
      prev_q      <= '0;
      accepted_q  <= '0;
      stable_q    <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
    end else begin
      div_q       <= div_d;
      row_meta_q  <= ROW;
      row_sync_q  <= row_meta_q;
      snap_q      <= snap_d;
      prev_q      <= prev_d;
      accepted_q  <= accepted_d;
      stable_q    <= stable_d;
      key_valid_q <= press_event;
      if (press_event) begin
        key_code_q <= snap_code;
      end
    end
  end

  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;

endmodule

// File: rtl/keypad_bcd_entry.sv
// Keypad to 3-digit BCD entry: digits shift in from the right, '*' clears, '#' signals a value.
module keypad_bcd_entry
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEBOUNCE_SCANS = 20
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [NUM_ROWS-1:0] ROW,
  output logic [NUM_COLS-1:0] COL,
  output logic                key_valid,
  output logic [3:0]          key_code,
  output logic [3:0]          units,
  output logic [3:0]          tens,
  output logic [3:0]          hundreds,
  output logic                value_valid
);

  logic [3:0] units_q, units_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] hundreds_q, hundreds_d;
  logic       value_valid_q, value_valid_d;

  keypad_scanner #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) u_scanner (
    .CLK       (CLK),
    .RESET     (RESET),
    .ROW       (ROW),
    .COL       (COL),
    .key_valid (key_valid),
    .key_code  (key_code)
  );

  always_comb begin
    units_d       = units_q;
    tens_d        = tens_q;
    hundreds_d    = hundreds_q;
    value_valid_d = 1'b0;
    if (key_valid) begin
      if (key_code <= 4'd9) begin
        hundreds_d = tens_q;
        tens_d     = units_q;
        units_d    = key_code;
      end else if (key_code == KEY_STAR) begin
        hundreds_d = '0;
        tens_d     = '0;
        units_d    = '0;
      end else if (key_code == KEY_HASH) begin
        value_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      units_q       <= '0;
      tens_q        <= '0;
      hundreds_q    <= '0;
      value_valid_q <= 1'b0;
    end else begin
      units_q       <= units_d;
      tens_q        <= tens_d;
      hundreds_q    <= hundreds_d;
      value_valid_q <= value_valid_d;
    end
  end

  assign units       = units_q;
  assign tens        = tens_q;
  assign hundreds    = hundreds_q;
  assign value_valid = value_valid_q;

endmodule

// File: tb/tb_keypad_bcd_entry.sv
// Bench for keypad_bcd_entry: sweep-aligned key phases checked against a phase-level model.
module tb_keypad_bcd_entry;

  localparam int unsigned SCAN_DIV       = 4;
  localparam int unsigned DEBOUNCE_SCANS = 3;
  localparam int SWEEP = 3 * SCAN_DIV;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [3:0]  ROW;
  logic [2:0]  COL;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [3:0]  units, tens, hundreds;
  logic        value_valid;

  logic [11:0] keys;  // bit r*3+c = key at row r, column c held

  int n_tests = 0;
  int n_fail  = 0;
  int n_kv    = 0;
  int n_vv    = 0;

  logic [3:0]  exp_q[$];
  logic [11:0] m_bcd;
  logic [3:0]  m_code;
  logic        m_vv_pend;
  logic [11:0] m_acc;
  logic [3:0]  m_c;

  logic [11:0] ph_mask[$];
  int          ph_len[$];

  keypad_bcd_entry #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .ROW         (ROW),
    .COL         (COL),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .units       (units),
    .tens        (tens),
    .hundreds    (hundreds),
    .value_valid (value_valid)
  );

  always #5 CLK = ~CLK;

  // A held key shorts its row to its column whenever that column is driven low.
  always_comb begin
    ROW = 4'hF;
    for (int r = 0; r < 4; r++) begin
      ROW[r] = ~|(keys[r*3 +: 3] & ~COL);
    end
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] code_of_idx(input int idx);
    logic [3:0] c;
    if (idx < 9) c = 4'(idx + 1);
    else if (idx == 9) c = 4'hA;
    else if (idx == 10) c = 4'h0;
    else c = 4'hB;
    return c;
  endfunction

  function automatic logic [11:0] k(input logic [3:0] code);
    logic [11:0] m;
    m = '0;
    for (int i = 0; i < 12; i++) begin
      if (code_of_idx(i) == code) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [3:0] code_of_mask(input logic [11:0] m);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 12; i++) begin
      if (m[i]) c = code_of_idx(i);
    end
    return c;
  endfunction

  // Scoreboard: every cycle out of reset, compare outputs with the edit model.
  always @(negedge CLK) begin
    if (!RESET) begin
      check("bcd", {4'h0, hundreds, tens, units}, {4'h0, m_bcd});
      check("value_valid", {15'h0, value_valid}, {15'h0, m_vv_pend});
      if (value_valid) n_vv++;
      m_vv_pend = 1'b0;
      if (key_valid) begin
        n_kv++;
        if (exp_q.size() == 0) begin
          check("kv_unexpected", 16'd1, 16'd0);
        end else begin
          m_c    = exp_q.pop_front();
          m_code = m_c;
          if (m_c <= 4'd9) m_bcd = {m_bcd[7:0], m_c};
          else if (m_c == 4'hA) m_bcd = '0;
          else if (m_c == 4'hB) m_vv_pend = 1'b1;
        end
      end
      check("key_code", {12'h0, key_code}, {12'h0, m_code});
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_col"}, {13'h0, COL}, 16'h6);
    check({tag, "_kv"}, {15'h0, key_valid}, 16'h0);
    check({tag, "_code"}, {12'h0, key_code}, 16'h0);
    check({tag, "_bcd"}, {4'h0, hundreds, tens, units}, 16'h0);
    check({tag, "_vv"}, {15'h0, value_valid}, 16'h0);
  endtask

  // Wait for the first cycle of column 0; bounded.
  task automatic align();
    logic [2:0] last;
    bit found;
    found = 1'b0;
    last  = COL;
    for (int i = 0; i < 4 * SWEEP && !found; i++) begin
      @(posedge CLK);
      #1;
      if (COL == 3'b110 && last == 3'b011) found = 1'b1;
      last = COL;
    end
    check("align", {15'h0, found}, 16'h1);
  endtask

  task automatic add_phase(input logic [11:0] m, input int len);
    ph_mask.push_back(m);
    ph_len.push_back(len);
  endtask

  // A run of identical sweeps is accepted once it lasts DEBOUNCE_SCANS+1 sweeps.
  task automatic run_scenario();
    logic [11:0] mm[$];
    int          ml[$];
    for (int i = 0; i < ph_mask.size(); i++) begin
      if (mm.size() > 0 && mm[mm.size()-1] == ph_mask[i]) ml[ml.size()-1] += ph_len[i];
      else begin
        mm.push_back(ph_mask[i]);
        ml.push_back(ph_len[i]);
      end
    end
    for (int i = 0; i < mm.size(); i++) begin
      if (ml[i] >= int'(DEBOUNCE_SCANS) + 1) begin
        if (m_acc == '0 && $countones(mm[i]) == 1) exp_q.push_back(code_of_mask(mm[i]));
        m_acc = mm[i];
      end
    end
    align();
    for (int i = 0; i < ph_mask.size(); i++) begin
      keys = ph_mask[i];
      repeat (ph_len[i] * SWEEP) @(posedge CLK);
      #1;
    end
    keys = '0;
    repeat (2 * SWEEP) @(posedge CLK);
    #1;
    check("pending", 16'(exp_q.size()), 16'd0);
    ph_mask.delete();
    ph_len.delete();
  endtask

  task automatic end_checks(input string tag, input int kv0, input int vv0, input int kv_d,
                            input int vv_d, input logic [11:0] bcd);
    check({tag, "_kv_count"}, 16'(n_kv - kv0), 16'(kv_d));
    check({tag, "_vv_count"}, 16'(n_vv - vv0), 16'(vv_d));
    check({tag, "_digits"}, {4'h0, hundreds, tens, units}, {4'h0, bcd});
  endtask

  initial begin
    int kv0, vv0;
    logic [11:0] m;
    int sel;
    RESET     = 1'b1;
    keys      = '0;
    m_bcd     = '0;
    m_code    = '0;
    m_vv_pend = 1'b0;
    m_acc     = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_reset_outputs("rst_init");
    @(posedge CLK);
    #1 RESET = 1'b0;

    // 1: 1 2 3 #
    kv0 = n_kv; vv0 = n_vv;
    add_phase(k(4'h1), 5); add_phase('0, 5);
    add_phase(k(4'h2), 5); add_phase('0, 5);
    add_phase(k(4'h3), 5); add_phase('0, 5);
    add_phase(k(4'hB), 5); add_phase('0, 5);
    run_scenario();
    end_checks("t1", kv0, vv0, 4, 1, 12'h123);

    // 2: 1 2 3 4, fourth digit drops the old hundreds
    kv0 = n_kv; vv0 = n_vv;
    for (int d = 1; d <= 4; d++) begin
      add_phase(k(4'(d)), 5); add_phase('0, 5);
    end
    run_scenario();
    end_checks("t2", kv0, vv0, 4, 0, 12'h234);

    // 3: bouncing '5' then held, followed by a 2-sweep glitch
    kv0 = n_kv; vv0 = n_vv;
    add_phase(k(4'h5), 1); add_phase('0, 1); add_phase(k(4'h5), 4); add_phase('0, 5);
    add_phase(k(4'h5), 2); add_phase('0, 5);
    run_scenario();
    end_checks("t3", kv0, vv0, 1, 0, 12'h345);

    // 4: 5+6 together, release, then 7
    kv0 = n_kv; vv0 = n_vv;
    add_phase(k(4'h5) | k(4'h6), 6); add_phase('0, 5);
    add_phase(k(4'h7), 5); add_phase('0, 5);
    run_scenario();
    end_checks("t4", kv0, vv0, 1, 0, 12'h457);

    // 5: 2 3 4 then '*'
    kv0 = n_kv; vv0 = n_vv;
    for (int d = 2; d <= 4; d++) begin
      add_phase(k(4'(d)), 5); add_phase('0, 5);
    end
    add_phase(k(4'hA), 5); add_phase('0, 5);
    run_scenario();
    end_checks("t5", kv0, vv0, 4, 0, 12'h000);
    check("t5_code", {12'h0, key_code}, 16'hA);

    // 6: '9' held through a mid-sweep reset
    kv0 = n_kv; vv0 = n_vv;
    align();
    keys = k(4'h9);
    repeat (SWEEP + SWEEP / 2) @(posedge CLK);
    #1;
    check("t6_pre_kv", 16'(n_kv - kv0), 16'd0);
    RESET     = 1'b1;
    m_bcd     = '0;
    m_code    = '0;
    m_vv_pend = 1'b0;
    m_acc     = '0;
    repeat (3) begin
      @(negedge CLK);
      check_reset_outputs("t6_rst");
      @(posedge CLK);
    end
    #1 RESET = 1'b0;
    kv0 = n_kv; vv0 = n_vv;
    exp_q.push_back(4'h9);
    repeat (10 * SWEEP) @(posedge CLK);
    #1 keys = '0;
    repeat (6 * SWEEP) @(posedge CLK);
    #1;
    check("t6_pending", 16'(exp_q.size()), 16'd0);
    end_checks("t6", kv0, vv0, 1, 0, 12'h009);
    m_acc = '0;

    // 7: random phases mixing singles, pairs, releases, glitches and bounces
    for (int s = 0; s < 4; s++) begin
      for (int p = 0; p < 8; p++) begin
        sel = int'($urandom_range(0, 9));
        if (sel < 2) m = '0;
        else if (sel < 8) m = 12'h001 << $urandom_range(0, 11);
        else m = (12'h001 << $urandom_range(0, 11)) | (12'h001 << $urandom_range(0, 11));
        add_phase(m, int'($urandom_range(1, 6)));
      end
      add_phase('0, 5);
      run_scenario();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
